// File: rtl/ddr4_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ddr4_cmd_sequencer
// Description : Turns single-burst read/write requests into DDR4 command-bus
//               sequences (ACT -> RD/WR -> data burst -> PRE) for the DIMM
//               model. Every request closes its page. Cycle timing is set by
//               parameters.
//   Ports     : ck_t/reset_n         clock, async active-low reset
//               req_*                request handshake and fields
//               rdata*               registered read beats
//               cke,cs_n,act_n,A,bg,ba  command / address pins
//               dq_o,dq_oe,dq_i      data pins (tristate built above)
//               dqs_t_o,dqs_c_o      write strobes
// Revision    : 1.0 - initial release
// ============================================================================
module ddr4_cmd_sequencer #(
    parameter int BGWIDTH     = 2,
    parameter int BAWIDTH     = 2,
    parameter int ADDRWIDTH   = 17,
    parameter int COLWIDTH    = 10,
    parameter int CHIPS       = 16,
    parameter int DQWIDTH     = 64,
    parameter int BL          = 8,
    parameter int TRCD        = 15,
    parameter int TCL         = 15,
    parameter int TCWL        = 0,
    parameter int TRP         = 15,
    parameter int INIT_CYCLES = 5
) (
    input  logic                  ck_t,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [BGWIDTH-1:0]    req_bg,
    input  logic [BAWIDTH-1:0]    req_ba,
    input  logic [ADDRWIDTH-1:0]  req_row,
    input  logic [COLWIDTH-1:0]   req_col,
    input  logic [BL*DQWIDTH-1:0] req_wdata,
    output logic                  rdata_valid,
    output logic [DQWIDTH-1:0]    rdata,
    output logic                  rdata_last,
    output logic                  cke,
    output logic                  cs_n,
    output logic                  act_n,
    output logic [ADDRWIDTH-1:0]  A,
    output logic [BGWIDTH-1:0]    bg,
    output logic [BAWIDTH-1:0]    ba,
    output logic [DQWIDTH-1:0]    dq_o,
    output logic                  dq_oe,
    input  logic [DQWIDTH-1:0]    dq_i,
    output logic [CHIPS-1:0]      dqs_t_o,
    output logic [CHIPS-1:0]      dqs_c_o
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int c_max   = f_max(f_max(f_max(TRCD, TRP), f_max(INIT_CYCLES, BL)),
                                   f_max(TCL + BL, TCWL + BL));
    localparam int c_cnt_w = $clog2(c_max + 1);

    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_bl      = c_cnt_w'(BL);
    localparam logic [c_cnt_w-1:0] c_init    = c_cnt_w'(INIT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_trcd_m1 = c_cnt_w'(TRCD - 1);
    localparam logic [c_cnt_w-1:0] c_trp_m1  = c_cnt_w'(TRP - 1);
    // BURST covers the data latency plus all beats except the one that may
    // share the command cycle; the counter then equals BL-k during beat k.
    localparam logic [c_cnt_w-1:0] c_rd_len  = c_cnt_w'(TCL + BL - 1);
    localparam logic [c_cnt_w-1:0] c_wr_len  = c_cnt_w'(TCWL + BL - 1);

    localparam logic [ADDRWIDTH-1:0] c_a_nop = ADDRWIDTH'(17'h1C000);
    localparam logic [ADDRWIDTH-1:0] c_a_pre = ADDRWIDTH'(17'h08000);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_ACT      = 3'd2,
        S_WAIT_RCD = 3'd3,
        S_CMD      = 3'd4,
        S_BURST    = 3'd5,
        S_PRE      = 3'd6,
        S_WAIT_RP  = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_cnt_w-1:0]      w_cnt_nxt;
    logic                    r_cke;
    logic                    r_write;
    logic [BGWIDTH-1:0]      r_bg;
    logic [BAWIDTH-1:0]      r_ba;
    logic [ADDRWIDTH-1:0]    r_row;
    logic [COLWIDTH-1:0]     r_col;
    logic [BL*DQWIDTH-1:0]   r_wdata;
    logic                    r_rdata_valid;
    logic [DQWIDTH-1:0]      r_rdata;
    logic                    r_rdata_last;

    logic                    w_accept;
    logic                    w_sample;
    logic                    w_wr_beat;
    logic [c_cnt_w-1:0]      w_beat_idx;
    logic [DQWIDTH-1:0]      w_beat_data;
    logic [ADDRWIDTH-1:0]    w_a_cmd;

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign cke         = r_cke;
    assign rdata_valid = r_rdata_valid;
    assign rdata       = r_rdata;
    assign rdata_last  = r_rdata_last;

    // In the command cycle only beat 0 can be live (TCWL = 0).
    assign w_beat_idx = (r_state == S_CMD) ? '0 : (c_bl - r_cnt);

    always_comb begin
        w_beat_data = '0;
        for (int k = 0; k < BL; k++) begin
            if (w_beat_idx == c_cnt_w'(k)) begin
                w_beat_data = r_wdata[k*DQWIDTH +: DQWIDTH];
            end
        end
    end

    always_comb begin
        w_a_cmd              = '0;
        w_a_cmd[COLWIDTH-1:0] = r_col;
        w_a_cmd[10]          = 1'b0;               // no auto-precharge
        w_a_cmd[16:14]       = r_write ? 3'b100 : 3'b101;
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_INIT;
            r_cnt         <= c_init;
            r_cke         <= 1'b0;
            r_write       <= 1'b0;
            r_bg          <= '0;
            r_ba          <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_wdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_rdata_last  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cke         <= 1'b1;
            if (w_accept) begin
                r_write <= req_write;
                r_bg    <= req_bg;
                r_ba    <= req_ba;
                r_row   <= req_row;
                r_col   <= req_col;
                r_wdata <= req_wdata;
            end
            r_rdata_valid <= w_sample;
            r_rdata       <= w_sample ? dq_i : '0;
            r_rdata_last  <= w_sample && (r_cnt == c_one);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        req_ready   = 1'b0;
        cs_n        = 1'b0;
        act_n       = 1'b1;
        A           = c_a_nop;
        bg          = r_bg;
        ba          = r_ba;
        w_sample    = 1'b0;
        w_wr_beat   = 1'b0;
        dq_o        = '0;
        dq_oe       = 1'b0;
        dqs_t_o     = '0;
        dqs_c_o     = '1;

        case (r_state)
            S_INIT: begin
                cs_n = 1'b1;
                A    = '0;
                bg   = '0;
                ba   = '0;
                // The count starts only once cke has gone high.
                if (r_cke) begin
                    if (r_cnt == c_one) w_state_nxt = S_IDLE;
                    else                w_cnt_nxt   = r_cnt - c_one;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                bg        = '0;
                ba        = '0;
                if (req_valid) w_state_nxt = S_ACT;
            end
            S_ACT: begin
                act_n       = 1'b0;
                A           = r_row;
                w_cnt_nxt   = c_trcd_m1;
                w_state_nxt = (TRCD == 1) ? S_CMD : S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                if (r_cnt == c_one) w_state_nxt = S_CMD;
                else                w_cnt_nxt   = r_cnt - c_one;
            end
            S_CMD: begin
                A         = w_a_cmd;
                w_cnt_nxt = r_write ? c_wr_len : c_rd_len;
                if (r_write && (TCWL == 0)) w_wr_beat = 1'b1;
                if (r_write && (c_wr_len == '0)) w_state_nxt = S_PRE;
                else                             w_state_nxt = S_BURST;
            end
            S_BURST: begin
                if (r_cnt <= c_bl) begin
                    if (r_write) w_wr_beat = 1'b1;
                    else         w_sample  = 1'b1;
                end
                if (r_cnt == c_one) w_state_nxt = S_PRE;
                else                w_cnt_nxt   = r_cnt - c_one;
            end
            S_PRE: begin
                A           = c_a_pre;
                w_cnt_nxt   = c_trp_m1;
                w_state_nxt = (TRP == 1) ? S_IDLE : S_WAIT_RP;
            end
            S_WAIT_RP: begin
                if (r_cnt == c_one) w_state_nxt = S_IDLE;
                else                w_cnt_nxt   = r_cnt - c_one;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase

        if (w_wr_beat) begin
            dq_oe   = 1'b1;
            dq_o    = w_beat_data;
            dqs_t_o = '1;
            dqs_c_o = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr4_cmd_sequencer
// Description : Directed self-checking bench for ddr4_cmd_sequencer. Cycle 0
//               of each request is the accept cycle; outputs are sampled 1
//               time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr4_cmd_sequencer;

    logic          ck_t;
    logic          reset_n;
    logic          req_valid, req_valid2;
    logic          req_write;
    logic [1:0]    req_bg, req_ba;
    logic [16:0]   req_row;
    logic [9:0]    req_col;
    logic [511:0]  req_wdata;
    logic [63:0]   dq_i;

    logic          req_ready, rdata_valid, rdata_last, cke, cs_n, act_n, dq_oe;
    logic [63:0]   rdata, dq_o;
    logic [16:0]   A;
    logic [1:0]    bg, ba;
    logic [15:0]   dqs_t_o, dqs_c_o;

    logic          req_ready2, rdata_valid2, rdata_last2, cke2, cs_n2, act_n2, dq_oe2;
    logic [63:0]   rdata2, dq_o2;
    logic [16:0]   A2;
    logic [1:0]    bg2, ba2;
    logic [15:0]   dqs_t2, dqs_c2;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [63:0] c_a5   = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] c_junk = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] c_step = 64'h1111_1111_1111_1111;

    ddr4_cmd_sequencer dut (
        .ck_t(ck_t), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .req_wdata(req_wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
        .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
        .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i),
        .dqs_t_o(dqs_t_o), .dqs_c_o(dqs_c_o)
    );

    ddr4_cmd_sequencer #(.TCWL(3), .TRCD(2)) dut2 (
        .ck_t(ck_t), .reset_n(reset_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .req_wdata(req_wdata),
        .rdata_valid(rdata_valid2), .rdata(rdata2), .rdata_last(rdata_last2),
        .cke(cke2), .cs_n(cs_n2), .act_n(act_n2), .A(A2), .bg(bg2), .ba(ba2),
        .dq_o(dq_o2), .dq_oe(dq_oe2), .dq_i(dq_i),
        .dqs_t_o(dqs_t2), .dqs_c_o(dqs_c2)
    );

    initial ck_t = 1'b0;
    always #5 ck_t = ~ck_t;

    task automatic set_request(input logic wr, input logic [16:0] row);
        req_write = wr;
        req_bg    = 2'd1;
        req_ba    = 2'd1;
        req_row   = row;
        req_col   = 10'd2;
        for (int k = 0; k < 8; k++) req_wdata[k*64 +: 64] = c_step * 64'(k);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge ck_t);
        #1;
        n_checks++; if (cke !== 1'b0) $display("FAIL rst_cke got=%b exp=0", cke); else n_pass++;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL rst_cs_n got=%b exp=1", cs_n); else n_pass++;
        n_checks++; if (dq_oe !== 1'b0) $display("FAIL rst_dq_oe got=%b exp=0", dq_oe); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", req_ready); else n_pass++;
        n_checks++; if (A !== 17'h0) $display("FAIL rst_A got=%h exp=0", A); else n_pass++;
        n_checks++; if (dqs_c_o !== 16'hFFFF) $display("FAIL rst_dqs_c got=%h exp=ffff", dqs_c_o); else n_pass++;
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge ck_t); #1;
            n_checks++; if (cke !== 1'b1) $display("FAIL init_cke cyc=%0d got=%b exp=1", cyc, cke); else n_pass++;
            n_checks++;
            if (req_ready !== (cyc == 6)) $display("FAIL init_ready cyc=%0d got=%b exp=%b", cyc, req_ready, cyc == 6);
            else n_pass++;
            n_checks++;
            if (cs_n !== (cyc < 6)) $display("FAIL init_cs_n cyc=%0d got=%b exp=%b", cyc, cs_n, cyc < 6);
            else n_pass++;
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 200 && req_ready !== 1'b1; i++) begin
            @(posedge ck_t); #1;
        end
        n_checks++; if (req_ready !== 1'b1) $display("FAIL %s_wait_ready got=%b exp=1", name, req_ready); else n_pass++;
    endtask

    task automatic test_write();
        logic [16:0] exp_a;
        logic        exp_oe;
        logic [63:0] exp_dq;
        wait_ready("wr");
        set_request(1'b1, 17'd1);
        req_valid = 1'b1;
        for (int cyc = 1; cyc <= 39; cyc++) begin
            @(posedge ck_t); #1;
            req_valid = 1'b0;
            exp_a  = (cyc == 1) ? 17'h00001 : (cyc == 16) ? 17'h10002 :
                     (cyc == 24) ? 17'h08000 : 17'h1C000;
            exp_oe = (cyc >= 16) && (cyc <= 23);
            exp_dq = exp_oe ? c_step * 64'(cyc - 16) : 64'h0;
            n_checks++; if (A !== exp_a) $display("FAIL wr_A cyc=%0d got=%h exp=%h", cyc, A, exp_a); else n_pass++;
            n_checks++; if (act_n !== (cyc != 1)) $display("FAIL wr_act_n cyc=%0d got=%b", cyc, act_n); else n_pass++;
            n_checks++; if (dq_oe !== exp_oe) $display("FAIL wr_dq_oe cyc=%0d got=%b exp=%b", cyc, dq_oe, exp_oe); else n_pass++;
            n_checks++; if (dq_o !== exp_dq) $display("FAIL wr_dq_o cyc=%0d got=%h exp=%h", cyc, dq_o, exp_dq); else n_pass++;
            n_checks++;
            if (dqs_t_o !== (exp_oe ? 16'hFFFF : 16'h0)) $display("FAIL wr_dqs_t cyc=%0d got=%h", cyc, dqs_t_o);
            else n_pass++;
            n_checks++; if (req_ready !== (cyc == 39)) $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, req_ready, cyc == 39); else n_pass++;
            n_checks++;
            if (bg !== ((cyc <= 38) ? 2'd1 : 2'd0)) $display("FAIL wr_bg cyc=%0d got=%0d", cyc, bg);
            else n_pass++;
        end
    endtask

    task automatic test_read();
        logic [16:0] exp_a;
        logic        exp_v;
        logic [63:0] exp_d;
        wait_ready("rd");
        set_request(1'b0, 17'd1);
        req_valid = 1'b1;
        for (int cyc = 1; cyc <= 54; cyc++) begin
            @(posedge ck_t); #1;
            req_valid = 1'b0;
            dq_i  = (cyc >= 31 && cyc <= 38) ? c_a5 + 64'(cyc - 31) : c_junk;
            exp_a = (cyc == 1) ? 17'h00001 : (cyc == 16) ? 17'h14002 :
                    (cyc == 39) ? 17'h08000 : 17'h1C000;
            exp_v = (cyc >= 32) && (cyc <= 39);
            exp_d = c_a5 + 64'(cyc - 32);
            n_checks++; if (A !== exp_a) $display("FAIL rd_A cyc=%0d got=%h exp=%h", cyc, A, exp_a); else n_pass++;
            n_checks++; if (rdata_valid !== exp_v) $display("FAIL rd_valid cyc=%0d got=%b exp=%b", cyc, rdata_valid, exp_v); else n_pass++;
            if (exp_v) begin
                n_checks++; if (rdata !== exp_d) $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, rdata, exp_d); else n_pass++;
            end
            n_checks++; if (rdata_last !== (cyc == 39)) $display("FAIL rd_last cyc=%0d got=%b", cyc, rdata_last); else n_pass++;
            n_checks++; if (dq_oe !== 1'b0) $display("FAIL rd_dq_oe cyc=%0d got=%b exp=0", cyc, dq_oe); else n_pass++;
            n_checks++; if (req_ready !== (cyc == 54)) $display("FAIL rd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, cyc == 54); else n_pass++;
        end
        dq_i = c_junk;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_bg;
        wait_ready("b2b");
        set_request(1'b1, 17'd1);
        req_valid = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge ck_t); #1;
            if (cyc == 1) begin
                req_row = 17'd5;      // second request's fields; first must be latched
                req_bg  = 2'd2;
            end
            if (cyc == 40) req_valid = 1'b0;
            exp_bg = (cyc < 39) ? 2'd1 : (cyc == 39) ? 2'd0 : 2'd2;
            n_checks++;
            if (act_n !== !(cyc == 1 || cyc == 40)) $display("FAIL b2b_act_n cyc=%0d got=%b", cyc, act_n);
            else n_pass++;
            n_checks++; if (req_ready !== (cyc == 39)) $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, req_ready, cyc == 39); else n_pass++;
            n_checks++; if (bg !== exp_bg) $display("FAIL b2b_bg cyc=%0d got=%0d exp=%0d", cyc, bg, exp_bg); else n_pass++;
            n_checks++;
            if (dq_oe !== (cyc >= 16 && cyc <= 23)) $display("FAIL b2b_dq_oe cyc=%0d got=%b", cyc, dq_oe);
            else n_pass++;
            if (cyc == 16) begin
                n_checks++; if (A !== 17'h10002) $display("FAIL b2b_wr_A got=%h exp=10002", A); else n_pass++;
            end
            if (cyc == 40) begin
                n_checks++; if (A !== 17'h00005) $display("FAIL b2b_act2_A got=%h exp=00005", A); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_ready("rst_mid");
        set_request(1'b0, 17'd1);
        req_valid = 1'b1;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(posedge ck_t); #1;
            req_valid = 1'b0;
            dq_i = (cyc >= 31) ? c_a5 + 64'(cyc - 31) : c_junk;
            if (cyc == 33) begin
                n_checks++; if (rdata_valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", rdata_valid); else n_pass++;
            end
        end
        reset_n = 1'b0;
        #1;
        n_checks++; if (rdata_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", rdata_valid); else n_pass++;
        n_checks++; if (cke !== 1'b0) $display("FAIL mid_cke got=%b exp=0", cke); else n_pass++;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL mid_cs_n got=%b exp=1", cs_n); else n_pass++;
        n_checks++; if (A !== 17'h0) $display("FAIL mid_A got=%h exp=0", A); else n_pass++;
        n_checks++; if (bg !== 2'd0 || ba !== 2'd0) $display("FAIL mid_bgba got=%0d/%0d exp=0/0", bg, ba); else n_pass++;
        n_checks++; if (dqs_c_o !== 16'hFFFF) $display("FAIL mid_dqs_c got=%h exp=ffff", dqs_c_o); else n_pass++;
        repeat (2) @(posedge ck_t);
        #1;
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge ck_t); #1;
            dq_i = c_a5 + 64'(cyc);
            n_checks++; if (rdata_valid !== 1'b0) $display("FAIL mid_post_valid cyc=%0d got=%b", cyc, rdata_valid); else n_pass++;
            n_checks++; if (req_ready !== (cyc >= 6)) $display("FAIL mid_init_ready cyc=%0d got=%b exp=%b", cyc, req_ready, cyc >= 6); else n_pass++;
        end
        dq_i = c_junk;
    endtask

    task automatic test_tcwl_trcd();
        logic [16:0] exp_a;
        logic        exp_oe;
        logic [63:0] exp_dq;
        for (int i = 0; i < 200 && req_ready2 !== 1'b1; i++) begin
            @(posedge ck_t); #1;
        end
        n_checks++; if (req_ready2 !== 1'b1) $display("FAIL tcwl_wait_ready got=%b exp=1", req_ready2); else n_pass++;
        set_request(1'b1, 17'd1);
        req_valid2 = 1'b1;
        for (int cyc = 1; cyc <= 29; cyc++) begin
            @(posedge ck_t); #1;
            req_valid2 = 1'b0;
            exp_a  = (cyc == 1) ? 17'h00001 : (cyc == 3) ? 17'h10002 :
                     (cyc == 14) ? 17'h08000 : 17'h1C000;
            exp_oe = (cyc >= 6) && (cyc <= 13);
            exp_dq = exp_oe ? c_step * 64'(cyc - 6) : 64'h0;
            n_checks++; if (A2 !== exp_a) $display("FAIL tcwl_A cyc=%0d got=%h exp=%h", cyc, A2, exp_a); else n_pass++;
            n_checks++; if (act_n2 !== (cyc != 1)) $display("FAIL tcwl_act_n cyc=%0d got=%b", cyc, act_n2); else n_pass++;
            n_checks++; if (dq_oe2 !== exp_oe) $display("FAIL tcwl_dq_oe cyc=%0d got=%b exp=%b", cyc, dq_oe2, exp_oe); else n_pass++;
            n_checks++; if (dq_o2 !== exp_dq) $display("FAIL tcwl_dq_o cyc=%0d got=%h exp=%h", cyc, dq_o2, exp_dq); else n_pass++;
            n_checks++; if (req_ready2 !== (cyc == 29)) $display("FAIL tcwl_ready cyc=%0d got=%b exp=%b", cyc, req_ready2, cyc == 29); else n_pass++;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
        req_write  = 1'b0;
        req_bg     = '0;
        req_ba     = '0;
        req_row    = '0;
        req_col    = '0;
        req_wdata  = '0;
        dq_i       = c_junk;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_tcwl_trcd();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr4_cmd_sequencer.md
Name: ddr4_cmd_sequencer

Overview:
- Upstream stage of the DIMM model. Converts single-burst read/write requests into DDR4 command-bus sequences with programmable cycle timing.
- Drives the DIMM model's command, address and data pins.
- Uses a closed-page policy: every request runs ACT → RD/WR → data burst → PRE.
- Replaces the hand-scripted stimulus currently used in DIMM benches.

Parameters:
- BGWIDTH, 2, bank-group address width
- BAWIDTH, 2, bank address width
- ADDRWIDTH, 17, row / command address width (A bus); must be ≥ 17
- COLWIDTH, 10, column address width
- CHIPS, 16, chips per rank; also the dqs width
- DQWIDTH, 64, data bus width
- BL, 8, burst length in beats
- TRCD, 15, cycles from ACT to RD/WR (≥ 1)
- TCL, 15, cycles from RD to first read beat (≥ 1)
- TCWL, 0, cycles from WR to first write beat (≥ 0)
- TRP, 15, cycles from PRE to next accept (≥ 1)
- INIT_CYCLES, 5, cycles after reset release before the first accept (≥ 1)

Ports:
- ck_t  in  1  sequencer clock; all logic on the rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_bg  in  BGWIDTH  bank group
- req_ba  in  BAWIDTH  bank
- req_row  in  ADDRWIDTH  row address
- req_col  in  COLWIDTH  column address
- req_wdata  in  BL*DQWIDTH  write burst; beat k = bits [k*DQWIDTH +: DQWIDTH]
- rdata_valid  out  1  one read beat valid this cycle
- rdata  out  DQWIDTH  read beat data
- rdata_last  out  1  high with the final beat of a burst
- cke  out  1  clock enable
- cs_n  out  1  chip select
- act_n  out  1  activate command
- A  out  ADDRWIDTH  address / command bits
- bg  out  BGWIDTH  bank group pins
- ba  out  BAWIDTH  bank pins
- dq_o  out  DQWIDTH  write data
- dq_oe  out  1  dq / dqs output enable; the top level builds the tristate
- dq_i  in  DQWIDTH  read data from the dq pins
- dqs_t_o  out  CHIPS  strobe, true
- dqs_c_o  out  CHIPS  strobe, complement

Behaviour:
- Reset (asynchronous, while reset_n = 0), all outputs forced:
  - req_ready=0, rdata_valid=0, rdata=0, rdata_last=0
  - cke=0, cs_n=1, act_n=1, A=0, bg=0, ba=0
  - dq_o=0, dq_oe=0, dqs_t_o=0, dqs_c_o=all 1s
  - Asserting reset mid-operation drops the in-flight request; no further rdata_valid appears for it.
- State machine: INIT → IDLE → ACT → WAIT_RCD → CMD → BURST → PRE → WAIT_RP → IDLE. One down-counter, sized for the largest timing parameter, drives all waits.
- INIT:
  - cke=1 from the first clock after reset release; cs_n stays 1.
  - Lasts INIT_CYCLES cycles, then IDLE.
- NOP encoding, used in every cycle with no command:
  - cs_n=0, act_n=1, A[16:14]=3'b111, other A bits 0.
  - bg/ba hold the request's values while a request is in flight; 0 in IDLE.
- IDLE:
  - req_ready=1.
  - On accept, all req_* fields are registered and the state moves to ACT.
  - req_ready is low in every other state; req_valid outside IDLE is ignored.
- ACT (accept cycle = cycle 0, ACT issued at cycle 1):
  - act_n=0, A=row, bg/ba = the request's values.
- CMD (issued at cycle 1+TRCD):
  - act_n=1. A[16:14] = 3'b100 for WR, 3'b101 for RD.
  - A[COLWIDTH-1:0]=col. Bit A[10] is forced to 0 (no auto-precharge). Remaining bits are 0.
- Write burst:
  - Beats k=0..BL-1 occur at cycle CMD+TCWL+k.
  - dq_oe=1, dq_o=beat k, dqs_t_o=all 1s, dqs_c_o=all 0s. Outside the burst these return to their reset values.
  - With TCWL=0, the first beat coincides with the WR command cycle.
- Read burst:
  - dq_i is sampled at cycles CMD+TCL+k.
  - rdata_valid=1 and rdata=the sample, both one cycle later (registered).
  - rdata_last is asserted with beat BL-1.
- PRE: issued the cycle after the last data beat (read: the last sample cycle). A[16:14]=3'b010, other A bits 0.
- WAIT_RP: TRP cycles of NOP, then IDLE; req_ready rises at PRE+TRP.
- Latency with defaults:
  - Write: ACT@1, WR@16, beats @16..23, PRE@24, ready@39.
  - Read: ACT@1, RD@16, samples @31..38, rdata_valid @32..39, PRE@39, ready@54.
- Arithmetic: counter loads are parameter minus one; nothing wraps. TCWL=0 skips the wait entirely.

Test Plan:
- Reset → cke=0, cs_n=1, dq_oe=0. Release → cke=1 next cycle; req_ready=1 exactly INIT_CYCLES=5 cycles later.
- Write, bg=1, ba=1, row=1, col=2, wdata beat k = 0x1111_1111_1111_1111*k:
  - act_n=0 with A=1 at cycle 1.
  - A=17'h10002 at cycle 16.
  - dq_o = beat k at cycles 16+k with dq_oe=1.
  - A=17'h08000 at cycle 24; req_ready at cycle 39.
- Read, same address, dq_i driven with 0xA5..A5+k at cycles 31+k:
  - A=17'h14002 at cycle 16.
  - rdata_valid at cycles 32..39 with matching data; rdata_last only at cycle 39.
  - PRE at 39; req_ready at 54.
- req_valid held high across two back-to-back requests → second ACT only after req_ready returns; no command overlap; no accept while busy.
- Reset asserted at cycle 34 of a read → all outputs at reset values immediately; no rdata_valid afterwards; INIT sequence restarts.
- TCWL=3, TRCD=2 override → WR@3, beats @6..13, PRE@14.
